uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver and buffers its output bytes. It consumes the receiver's held done and framing-error flags, and owns the receiver's reset. After every frame event it pulses that reset to re-arm the receiver. Received bytes go into a first-word-fall-through FIFO with a valid/ready drain port, and the block keeps overflow and framing-error status for the host side.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of 2, minimum 2.
CNT_W, $clog2(DEPTH+1), width of fifo_count (derived, not overridden).
TIMEOUT_CYC, 1024, idle-timeout threshold in rx_clk cycles; used only with RX_TIMEOUT_EN.

Ports:
rx_clk  in  1  oversampling clock; same clock as the receiver.
reset_n  in  1  reset; synchronous, active-low.
enable  in  1  1 = receive; 0 = hold receiver in reset.
rcv_data  in  8  receiver rx_data.
rcv_done  in  1  receiver rx_done; held high until the receiver is reset.
rcv_framing_error  in  1  receiver framing_error; held high until the receiver is reset.
rcv_reset  out  1  drives receiver reset (active-high); registered.
m_data  out  8  FIFO head byte.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts m_data.
fifo_count  out  CNT_W  bytes held, 0..DEPTH.
overflow  out  1  sticky; a byte was dropped because the FIFO was full.
frame_err_count  out  8  saturating count of framing errors.
clr_status  in  1  1-cycle pulse; clears overflow, frame_err_count and timeout.
timeout  out  1  sticky idle-timeout flag.

Behaviour:
- Reset (reset_n=0 at posedge): state=DISABLED, rcv_reset=1, FIFO emptied, m_valid=0, m_data=0, fifo_count=0, overflow=0, frame_err_count=0, timeout=0.
- FSM states: DISABLED, ARMED, CLEAR. All outputs are registered.
- DISABLED:
  - rcv_reset=1.
  - If enable=1, go to ARMED; rcv_reset=0 from that edge.
- ARMED:
  - rcv_reset=0.
  - If rcv_done=1: push rcv_data, then go to CLEAR.
  - If rcv_framing_error=1: frame_err_count+1 (saturates at 255), then go to CLEAR.
  - If both are high in the same cycle: push the byte AND count the error, then go to CLEAR once.
  - Otherwise stay in ARMED.
- CLEAR:
  - rcv_reset=1 for exactly one cycle, then ARMED.
  - The receiver's done and error flags are therefore low on the first ARMED cycle, so no event is ever double-counted.
- enable=0 in any state: go to DISABLED at the next edge. FIFO contents and status are retained. The drain port keeps operating.
- The enable check takes priority over an ARMED event in the same cycle; that event is discarded.
- Push rules:
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed, fifo_count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push is stored and the pop does nothing, since m_valid was 0.
- Pop: occurs when m_valid & m_ready at the clock edge. m_data shows the new head in the following cycle.
- Latency: rcv_done sampled high at edge N with the FIFO empty gives m_valid=1 and m_data=byte after edge N.
- Pointers: log2(DEPTH) bits and wrap naturally. fifo_count tracks occupancy and never exceeds DEPTH.
- clr_status:
  - Clears overflow, frame_err_count and timeout at the next edge.
  - If an overflow or a framing error occurs in that same cycle, the new event wins: the flag ends at 1, or the count ends at 1.
- m_data holds its last value while m_valid=0 and is not required to be zeroed.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- When defined:
  - An idle counter (width $clog2(TIMEOUT_CYC)) resets on any push, on any pop, or while the FIFO is empty; otherwise it increments.
  - When it reaches TIMEOUT_CYC-1 with the FIFO non-empty, timeout is set to 1 and the counter holds.
  - timeout clears on a pop or on clr_status. This lets the host drain partial messages.
- When undefined: timeout is tied to 0, no counter logic is built, and the port is still present.

Test Plan:
- Reset, enable=1, one byte: rcv_data=0xA5 with rcv_done held high until rcv_reset -> rcv_reset high exactly 1 cycle; m_valid=1 with m_data=0xA5 the cycle after done is sampled; fifo_count=1.
- Fill and overflow (DEPTH=8, m_ready=0): 9 bytes 0x01..0x09 -> fifo_count=8, overflow=1; drain yields 0x01..0x08 in order and 0x09 never appears.
- Simultaneous push/pop at full: 8 bytes held, m_ready=1 on the same cycle as a push of 0x55 -> fifo_count stays 8, overflow=0, 0x55 read last.
- Framing error: rcv_framing_error high 300 times -> frame_err_count=255, no FIFO push; one clr_status pulse -> 0.
- enable dropped mid-stream: 3 bytes buffered, enable=0 -> rcv_reset=1 held, FIFO still drains 3 bytes; enable=1 -> ARMED and the next byte is accepted.
- RX_TIMEOUT_EN with TIMEOUT_CYC=16: one byte pushed, m_ready=0 -> timeout=1 exactly 15 cycles after the push edge; a pop clears it.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Sequences a UART receiver by owning its reset. Received bytes go
//             into a first-word-fall-through FIFO with a valid/ready drain, and
//             overflow and framing-error status are kept for the host.
//  Options  : RX_TIMEOUT_EN - builds the sticky idle-timeout flag
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_ctrl #(
   parameter int DEPTH       = 8,
   parameter int CNT_W       = $clog2(DEPTH + 1),
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             rx_clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [7:0]       rcv_data,
   input  logic             rcv_done,
   input  logic             rcv_framing_error,
   output logic             rcv_reset,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow,
   output logic [7:0]       frame_err_count,
   input  logic             clr_status,
   output logic             timeout
);

   localparam int               c_ptr_w = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] c_full  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_CLEAR    = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;
   logic   w_evt_done;
   logic   w_evt_ferr;

   logic             r_rcv_reset;
   logic [7:0]       r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] w_rd_next;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;
   logic [7:0]       r_m_data;
   logic             r_m_valid;
   logic             r_overflow;
   logic [7:0]       r_fec;

   logic w_pop;
   logic w_push;
   logic w_full;
   logic w_empty;
   logic w_ovf_evt;

   // ------------------------------------------------------------------------
   // Receiver sequencing
   // ------------------------------------------------------------------------
   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_state <= ST_DISABLED;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Dropping enable wins over a same-cycle receiver event, which is discarded.
   always_comb begin
      w_state_next = r_state;
      w_evt_done   = 1'b0;
      w_evt_ferr   = 1'b0;
      if (!enable) begin
         w_state_next = ST_DISABLED;
      end else begin
         case (r_state)
            ST_DISABLED: w_state_next = ST_ARMED;
            ST_ARMED: begin
               w_evt_done = rcv_done;
               w_evt_ferr = rcv_framing_error;
               if (rcv_done || rcv_framing_error) begin
                  w_state_next = ST_CLEAR;
               end
            end
            ST_CLEAR: w_state_next = ST_ARMED;
            default:  w_state_next = ST_DISABLED;
         endcase
      end
   end

   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_rcv_reset <= 1'b1;
      end else begin
         r_rcv_reset <= (w_state_next != ST_ARMED);
      end
   end

   // ------------------------------------------------------------------------
   // FWFT FIFO
   // ------------------------------------------------------------------------
   assign w_full    = (r_count == c_full);
   assign w_empty   = (r_count == '0);
   assign w_pop     = r_m_valid && m_ready;
   assign w_push    = w_evt_done && (!w_full || w_pop);
   assign w_ovf_evt = w_evt_done && w_full && !w_pop;
   assign w_rd_next = r_rd_ptr + c_ptr_w'(1);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + c_one;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - c_one;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rcv_data;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         r_count <= w_count_next;
      end
   end

   // The head register is loaded straight from the receiver when the incoming
   // byte becomes the head, otherwise from the slot behind the popped entry.
   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_m_data  <= 8'h00;
         r_m_valid <= 1'b0;
      end else begin
         r_m_valid <= (w_count_next != '0);
         if (w_empty) begin
            if (w_push) begin
               r_m_data <= rcv_data;
            end
         end else if (w_pop) begin
            if (r_count != c_one) begin
               r_m_data <= r_mem[w_rd_next];
            end else if (w_push) begin
               r_m_data <= rcv_data;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Host status
   // ------------------------------------------------------------------------
   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_overflow <= 1'b0;
         r_fec      <= 8'h00;
      end else begin
         if (w_ovf_evt) begin
            r_overflow <= 1'b1;
         end else if (clr_status) begin
            r_overflow <= 1'b0;
         end

         if (w_evt_ferr) begin
            if (clr_status) begin
               r_fec <= 8'h01;
            end else if (r_fec != 8'hFF) begin
               r_fec <= r_fec + 8'h01;
            end
         end else if (clr_status) begin
            r_fec <= 8'h00;
         end
      end
   end

`ifdef RX_TIMEOUT_EN
   localparam int                c_idle_w   = $clog2(TIMEOUT_CYC);
   localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT_CYC - 1);
   localparam logic [c_idle_w-1:0] c_idle_pre = c_idle_w'(TIMEOUT_CYC - 2);

   logic [c_idle_w-1:0] r_idle;
   logic                r_timeout;
   logic                w_idle_rst;

   assign w_idle_rst = w_push || w_pop || w_empty;

   // The flag is raised only on the step into the terminal count, so a clear
   // while the counter sits saturated is not immediately undone.
   always_ff @(posedge rx_clk) begin
      if (!reset_n) begin
         r_idle    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_idle_rst) begin
            r_idle <= '0;
         end else if (r_idle != c_idle_max) begin
            r_idle <= r_idle + c_idle_w'(1);
         end

         if (!w_idle_rst && (r_idle == c_idle_pre)) begin
            r_timeout <= 1'b1;
         end else if (w_pop || clr_status) begin
            r_timeout <= 1'b0;
         end
      end
   end

   assign timeout = r_timeout;
`else
   logic w_unused_timeout_cfg;
   assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
   assign timeout              = 1'b0;
`endif

   assign rcv_reset       = r_rcv_reset;
   assign m_data          = r_m_data;
   assign m_valid         = r_m_valid;
   assign fifo_count      = r_count;
   assign overflow        = r_overflow;
   assign frame_err_count = r_fec;

endmodule

`default_nettype wire
